fan_pwm_ctrl: RTL and testbench

Register-configured fan PWM controller. It replaces the free-running fan_pwm counter tap in the top level. Software writes the period, prescale, target duty, ramp step and watchdog timeout through the AXI-lite register file, and the block ramps the duty cycle glitch-free toward the target. If software stops kicking the watchdog, the block forces the fan to full speed (failsafe).

---
 rtl/fan_ctrl_pkg.sv | 28 ++
 rtl/fan_wdog.sv | 34 +++
 rtl/fan_pwm_ctrl.sv | 155 +++++++++++++++
 tb/tb_fan_pwm_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared types and constants for the fan PWM controller.
//   state_t  - controller FSM encoding (visible on fan_pwm_ctrl.state)
//   cfg_t    - one set of PWM configuration (pending or applied copy)
//   FAILSAFE_DUTY - duty forced while the watchdog has expired
package fan_ctrl_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int PRE_W_DEF  = 16;
    localparam int WDOG_W_DEF = 32;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RAMP     = 2'd1,
        HOLD     = 2'd2,
        FAILSAFE = 2'd3
    } state_t;

    // All-ones is above any period, so the output stays high.
    localparam logic [CNT_W_DEF-1:0] FAILSAFE_DUTY = '1;

    typedef struct packed {
        logic [PRE_W_DEF-1:0] prescale;
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] duty_target;
        logic [CNT_W_DEF-1:0] ramp_step;
    } cfg_t;

endpackage

// File: rtl/fan_wdog.sv
// fan_wdog: software-kick watchdog for the fan controller.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_run         - count only while the controller is actively driving
//   i_kick        - one-cycle pulse, restarts the count
//   i_timeout     - clocks without a kick before expiry; 0 disables
//   o_expire      - one-cycle pulse, failsafe should be entered next cycle
module fan_wdog #(
    parameter int WDOG_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_kick,
    input  logic [WDOG_W-1:0] i_timeout,
    output logic              o_expire
);

    logic [WDOG_W-1:0] r_cnt;
    logic              w_armed;

    assign w_armed = i_run && (i_timeout != '0);

    // A kick in the expiry cycle wins. >= (not ==) so that lowering the
    // timeout below the running count still expires instead of wrapping.
    assign o_expire = w_armed && !i_kick && (r_cnt >= i_timeout - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_armed || i_kick || o_expire)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/fan_pwm_ctrl.sv
// fan_pwm_ctrl: register-configured fan PWM with glitch-free duty ramping
// and watchdog failsafe.
//   axi_aclk, axi_reset - clock, synchronous active-high reset
//   enable              - level, 0 forces OFF
//   cfg_load            - pulse, capture prescale/period/duty_target/ramp_step
//   wdog_timeout        - watchdog limit in clocks (0 disables), not shadowed
//   wdog_kick           - pulse, restart watchdog / leave failsafe
//   fan_pwm             - registered PWM output
//   duty_now            - duty currently applied
//   state               - FSM state (fan_ctrl_pkg::state_t encoding)
//   wdog_expired        - high while in FAILSAFE
//   period_done         - pulse in the cycle of each period wrap
module fan_pwm_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PRE_W  = PRE_W_DEF,
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  duty_target,
    input  logic [CNT_W-1:0]  ramp_step,
    input  logic [WDOG_W-1:0] wdog_timeout,
    input  logic              wdog_kick,
    output logic              fan_pwm,
    output logic [CNT_W-1:0]  duty_now,
    output logic [1:0]        state,
    output logic              wdog_expired,
    output logic              period_done
);

    state_t           r_state;
    cfg_t             r_pend;
    cfg_t             r_sh;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_duty;
    logic             r_pwm;

    cfg_t             w_cfg;
    logic             w_tick;
    logic             w_wrap;
    logic             w_run;
    logic             w_expire;
    logic [CNT_W-1:0] w_ramp_duty;
    logic [CNT_W:0]   w_clamp;

    // Move cur toward tgt by at most step; step 0 jumps straight there.
    // Distance is taken in CNT_W+1 bits so the compare cannot wrap.
    function automatic logic [CNT_W-1:0] ramp_toward(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] tgt,
        input logic [CNT_W-1:0] step
    );
        logic [CNT_W:0] diff;
        if (cur == tgt || step == '0)
            return tgt;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return ({1'b0, step} >= diff) ? tgt : cur + step;
        end
        diff = {1'b0, cur} - {1'b0, tgt};
        return ({1'b0, step} >= diff) ? tgt : cur - step;
    endfunction

    assign w_tick = (r_pre == r_sh.prescale);
    assign w_wrap = (r_state != OFF) && w_tick && (r_cnt == r_sh.period);
    assign w_run  = (r_state == RAMP) || (r_state == HOLD);

    // Config in effect after this edge: a wrap hands over the pending set,
    // and the ramp step taken at that wrap already uses the new target.
    assign w_cfg       = w_wrap ? r_pend : r_sh;
    assign w_ramp_duty = ramp_toward(r_duty, w_cfg.duty_target, w_cfg.ramp_step);

    // Failsafe recovery restarts from the highest duty that still matters.
    assign w_clamp = {1'b0, r_sh.period} + 1'b1;

    fan_wdog #(.WDOG_W(WDOG_W)) u_wdog (
        .i_clk     (axi_aclk),
        .i_rst     (axi_reset),
        .i_run     (w_run),
        .i_kick    (wdog_kick),
        .i_timeout (wdog_timeout),
        .o_expire  (w_expire)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state <= OFF;
            r_pend  <= '0;
            r_sh    <= '0;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_pend.prescale    <= prescale;
                r_pend.period      <= period;
                r_pend.duty_target <= duty_target;
                r_pend.ramp_step   <= ramp_step;
            end
            r_sh <= (r_state == OFF) ? r_pend : w_cfg;

            if (r_state == OFF) begin
                r_pre <= '0;
                r_cnt <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_cnt <= (r_cnt == r_sh.period) ? '0 : r_cnt + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            r_pwm <= (r_state == FAILSAFE) || (r_cnt < r_duty);

            if (!enable) begin
                r_state <= OFF;
                r_duty  <= '0;
            end else begin
                case (r_state)
                    OFF: r_state <= RAMP;
                    RAMP, HOLD: begin
                        if (w_expire) begin
                            r_state <= FAILSAFE;
                            r_duty  <= CNT_W'(FAILSAFE_DUTY);
                        end else if (w_wrap) begin
                            r_duty  <= w_ramp_duty;
                            r_state <= (w_ramp_duty == w_cfg.duty_target) ? HOLD : RAMP;
                        end
                    end
                    FAILSAFE: begin
                        if (wdog_kick) begin
                            r_state <= RAMP;
                            r_duty  <= w_clamp[CNT_W] ? '1 : w_clamp[CNT_W-1:0];
                        end
                    end
                    default: r_state <= OFF;
                endcase
            end
        end
    end

    assign fan_pwm      = r_pwm;
    assign duty_now     = r_duty;
    assign state        = r_state;
    assign wdog_expired = (r_state == FAILSAFE);
    assign period_done  = w_wrap;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// tb_fan_pwm_ctrl: directed scenarios plus randomized traffic, all checked
// against a phase/arithmetic model of the fan controller kept in this file.
module tb_fan_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_load = 1'b0;
    logic        kick = 1'b0;
    logic [15:0] prescale = '0;
    logic [15:0] period = '0;
    logic [15:0] duty_target = '0;
    logic [15:0] ramp_step = '0;
    logic [31:0] tmo = '0;

    logic        fan_pwm;
    logic [15:0] duty_now;
    logic [1:0]  state;
    logic        wdog_expired;
    logic        period_done;
    logic [20:0] dut_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fan_pwm_ctrl #(.CNT_W(16), .PRE_W(16), .WDOG_W(32)) dut (
        .axi_aclk     (clk),
        .axi_reset    (rst),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .prescale     (prescale),
        .period       (period),
        .duty_target  (duty_target),
        .ramp_step    (ramp_step),
        .wdog_timeout (tmo),
        .wdog_kick    (kick),
        .fan_pwm      (fan_pwm),
        .duty_now     (duty_now),
        .state        (state),
        .wdog_expired (wdog_expired),
        .period_done  (period_done)
    );

    assign dut_vec = {fan_pwm, duty_now, state, wdog_expired, period_done};

    // ---------------- reference model ----------------
    // State codes: 0 off, 1 ramp, 2 hold, 3 failsafe. Position in the period
    // is tracked as clocks elapsed (m_phase); a period lasts (pre+1)*(per+1).
    int     m_st = 0, m_duty = 0, m_pwm = 0;
    longint m_phase = 0, m_wd = 0;
    int     p_pre = 0, p_per = 0, p_tgt = 0, p_stp = 0;
    int     a_pre = 0, a_per = 0, a_tgt = 0, a_stp = 0;

    function automatic bit m_wrap();
        return (m_st != 0) && (m_phase == longint'(a_pre + 1) * longint'(a_per + 1) - 1);
    endfunction

    function automatic bit m_expire();
        return (m_st == 1 || m_st == 2) && tmo != 0 && kick == 1'b0 && m_wd >= longint'(tmo) - 1;
    endfunction

    function automatic int m_ramp(int cur, int tgt, int stp);
        if (stp == 0) return tgt;
        if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [15:0] d;
        logic [1:0]  s;
        d = 16'(m_duty);
        s = 2'(m_st);
        return {m_pwm != 0, d, s, m_st == 3, m_wrap()};
    endfunction

    task automatic model_step();
        bit     wr, ex;
        longint pos;
        int     st0;
        wr  = m_wrap();
        ex  = m_expire();
        pos = m_phase / (a_pre + 1);
        st0 = m_st;
        if (rst) begin
            m_st = 0; m_duty = 0; m_pwm = 0; m_phase = 0; m_wd = 0;
            p_pre = 0; p_per = 0; p_tgt = 0; p_stp = 0;
            a_pre = 0; a_per = 0; a_tgt = 0; a_stp = 0;
            return;
        end
        m_pwm   = (st0 == 3 || pos < m_duty) ? 1 : 0;
        m_wd    = ((st0 == 1 || st0 == 2) && tmo != 0 && !kick && !ex) ? m_wd + 1 : 0;
        m_phase = (st0 == 0 || wr) ? 0 : m_phase + 1;
        if (!enable) begin
            m_st = 0; m_duty = 0;
        end else if (st0 == 0) begin
            m_st = 1;
        end else if (st0 == 3) begin
            if (kick) begin
                m_st = 1;
                m_duty = (a_per + 1 > 65535) ? 65535 : a_per + 1;
            end
        end else if (ex) begin
            m_st = 3; m_duty = 65535;
        end else if (wr) begin
            m_duty = m_ramp(m_duty, p_tgt, p_stp);
            m_st = (m_duty == p_tgt) ? 2 : 1;
        end
        if (st0 == 0 || wr) begin
            a_pre = p_pre; a_per = p_per; a_tgt = p_tgt; a_stp = p_stp;
        end
        if (cfg_load) begin
            p_pre = int'(prescale); p_per = int'(period);
            p_tgt = int'(duty_target); p_stp = int'(ramp_step);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        kick = 1'b0;
    endtask

    task automatic load_cfg(input int pre, input int per, input int tgt, input int stp);
        prescale = 16'(pre); period = 16'(per); duty_target = 16'(tgt); ramp_step = 16'(stp);
        cfg_load = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec()); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n, highs, dones;
        load_cfg(0, 9, 3, 0); tick();
        enable = 1'b1; tick();
        n = 0;
        while (period_done !== 1'b1 && n < 50) begin
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_vec got=%h exp=%h", dut_vec, exp_vec()); end
            tick(); n++;
        end
        checks++; if (period_done !== 1'b1) begin errors++; $display("FAIL basic_first_wrap timeout got=%b exp=1", period_done); end
        highs = 0; dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_vec got=%h exp=%h", dut_vec, exp_vec()); end
            highs += int'(fan_pwm);
            dones += int'(period_done);
        end
        checks++; if (highs != 3) begin errors++; $display("FAIL basic_high_count got=%0d exp=3", highs); end
        checks++; if (dones != 1 || period_done !== 1'b1) begin errors++; $display("FAIL basic_period_done got=%0d/%b exp=1/1", dones, period_done); end
    endtask

    task automatic test_ramp_up();
        int n;
        int exp_d[3] = '{20, 40, 50};
        enable = 1'b0; tick(); tick();
        load_cfg(0, 99, 50, 20); tick();
        enable = 1'b1; tick();
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (period_done !== 1'b1 && n < 200) begin
                checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ramp_up_vec got=%h exp=%h", dut_vec, exp_vec()); end
                tick(); n++;
            end
            tick();
            checks++; if (duty_now !== 16'(exp_d[k])) begin errors++; $display("FAIL ramp_up_step%0d got=%0d exp=%0d", k, duty_now, exp_d[k]); end
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ramp_up_hold got=%0d exp=2", state); end
    endtask

    task automatic test_ramp_down();
        int n, prev;
        int exp_d[3] = '{30, 10, 5};
        for (int i = 0; i < 30; i++) tick();
        load_cfg(0, 99, 5, 20); tick();
        prev = 50;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (period_done !== 1'b1 && n < 200) begin
                checks++; if (duty_now !== 16'(prev)) begin errors++; $display("FAIL ramp_down_between got=%0d exp=%0d", duty_now, prev); end
                tick(); n++;
            end
            tick();
            checks++; if (duty_now !== 16'(exp_d[k])) begin errors++; $display("FAIL ramp_down_step%0d got=%0d exp=%0d", k, duty_now, exp_d[k]); end
            prev = exp_d[k];
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ramp_down_hold got=%0d exp=2", state); end
    endtask

    task automatic test_edge_duty();
        int n;
        enable = 1'b0; tick();
        load_cfg(0, 9, 0, 0); tick();
        enable = 1'b1; tick();
        for (int i = 0; i < 40; i++) begin
            checks++; if (fan_pwm !== 1'b0) begin errors++; $display("FAIL edge_zero got=%b exp=0", fan_pwm); end
            tick();
        end
        enable = 1'b0; tick();
        load_cfg(0, 9, 10, 0); tick();
        enable = 1'b1; tick();
        n = 0;
        while (period_done !== 1'b1 && n < 50) begin tick(); n++; end
        tick(); tick();
        for (int i = 0; i < 35; i++) begin
            checks++; if (fan_pwm !== 1'b1 || duty_now !== 16'd10) begin errors++; $display("FAIL edge_full got=%b/%0d exp=1/10", fan_pwm, duty_now); end
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL edge_vec got=%h exp=%h", dut_vec, exp_vec()); end
            tick();
        end
    endtask

    task automatic test_wdog();
        int n, c;
        enable = 1'b0; tick();
        tmo = 32'd1000;
        load_cfg(0, 9, 3, 0); tick();
        enable = 1'b1; tick();
        n = 0;
        while (wdog_expired !== 1'b1 && n < 1100) begin
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wdog_vec got=%h exp=%h", dut_vec, exp_vec()); end
            tick(); n++;
        end
        checks++; if (n != 1000 || state !== 2'd3) begin errors++; $display("FAIL wdog_expire_time got=%0d/%0d exp=1000/3", n, state); end
        tick();
        checks++; if (fan_pwm !== 1'b1 || duty_now !== 16'hFFFF) begin errors++; $display("FAIL wdog_failsafe_out got=%b/%h exp=1/ffff", fan_pwm, duty_now); end
        tick(); tick();
        kick = 1'b1; tick();
        checks++; if (state !== 2'd1 || duty_now !== 16'd10) begin errors++; $display("FAIL wdog_kick_ramp got=%0d/%0d exp=1/10", state, duty_now); end
        c = 0;
        while (period_done !== 1'b1 && c < 50) begin tick(); c++; end
        tick(); c++;
        checks++; if (duty_now !== 16'd3 || state !== 2'd2) begin errors++; $display("FAIL wdog_ramp_down got=%0d/%0d exp=3/2", duty_now, state); end
        while (c < 999) begin
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wdog_vec got=%h exp=%h", dut_vec, exp_vec()); end
            tick(); c++;
        end
        kick = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (state === 2'd3) begin errors++; $display("FAIL wdog_kick_at_expiry got=%0d exp=2", state); end
            tick();
        end
        for (int i = 0; i < 300; i++) tick();
        tmo = 32'd0;
        for (int i = 0; i < 1200; i++) tick();
        checks++; if (state !== 2'd2 || dut_vec !== exp_vec()) begin errors++; $display("FAIL wdog_disable got=%h exp=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_enable_reset();
        int n;
        tmo = 32'd20;
        n = 0;
        while (state !== 2'd3 && n < 100) begin tick(); n++; end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL er_failsafe got=%0d exp=3", state); end
        enable = 1'b0; tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL er_off_state got=%0d exp=0", state); end
        tick();
        checks++; if (fan_pwm !== 1'b0) begin errors++; $display("FAIL er_off_pwm got=%b exp=0", fan_pwm); end
        tmo = 32'd0;
        load_cfg(0, 99, 90, 10); tick();
        enable = 1'b1;
        for (int i = 0; i < 350; i++) begin
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL er_vec got=%h exp=%h", dut_vec, exp_vec()); end
            tick();
        end
        checks++; if (state !== 2'd1 || duty_now !== 16'd30) begin errors++; $display("FAIL er_midramp got=%0d/%0d exp=1/30", state, duty_now); end
        rst = 1'b1; tick();
        checks++; if (dut_vec !== '0) begin errors++; $display("FAIL er_reset got=%h exp=0", dut_vec); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        enable = 1'b1;
        tmo = 32'd100;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) enable = ~enable;
            if ($urandom_range(49) == 0)
                load_cfg(int'($urandom_range(3)), int'($urandom_range(15)),
                         int'($urandom_range(17)), int'($urandom_range(5)));
            if ($urandom_range(99) == 0) kick = 1'b1;
            if ($urandom_range(299) == 0)
                tmo = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(200, 30));
            rst = ($urandom_range(999) == 0);
            tick();
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_ramp_up();
        test_ramp_down();
        test_edge_duty();
        test_wdog();
        test_enable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
